line_rasterizer: RTL and testbench

- Upstream stage of the framebuffer write path. Accepts one line segment (two endpoints, any octant) through a valid/ready handshake.
- Runs an integer Bresenham walk and streams every pixel coordinate on the segment, one per cycle, through a valid/ready pixel port with backpressure.
- Downstream consumer (framebuffer writer / line sprite buffer) draws each emitted pixel; the colour is latched with the segment and carried alongside each pixel.

---
 rtl/line_rasterizer.sv | 157 +++++++++++++++
 tb/tb_line_rasterizer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one segment via valid/ready and streams
// each pixel coordinate (with the segment colour) one per cycle under backpressure.
module line_rasterizer #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10,
  parameter int COLOR_W = 24
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_valid_in,
  output logic               start_ready_out,
  input  logic [H_WIDTH-1:0] x0_in,
  input  logic [V_WIDTH-1:0] y0_in,
  input  logic [H_WIDTH-1:0] x1_in,
  input  logic [V_WIDTH-1:0] y1_in,
  input  logic [COLOR_W-1:0] color_in,
  output logic               pix_valid_out,
  input  logic               pix_ready_in,
  output logic [H_WIDTH-1:0] pix_x_out,
  output logic [V_WIDTH-1:0] pix_y_out,
  output logic [COLOR_W-1:0] pix_color_out,
  output logic               pix_last_out,
  output logic               done_out
);

  localparam int ERR_W = ((H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH) + 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [H_WIDTH-1:0]       curX_q, curX_d, endX_q, endX_d;
  logic [V_WIDTH-1:0]       curY_q, curY_d, endY_q, endY_d;
  logic [COLOR_W-1:0]       color_q, color_d;
  logic signed [ERR_W-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                     sxNeg_q, sxNeg_d, syNeg_q, syNeg_d;
  logic                     valid_q, valid_d, done_q, done_d;

  // Endpoints are zero-extended into the signed error width before subtracting.
  logic signed [ERR_W-1:0]  x0W, x1W, y0W, y1W, xDiff, yDiff, dxAbs, dyAbs, e2;
  logic                     isLast, handshake;

  assign x0W   = $signed({{(ERR_W-H_WIDTH){1'b0}}, x0_in});
  assign x1W   = $signed({{(ERR_W-H_WIDTH){1'b0}}, x1_in});
  assign y0W   = $signed({{(ERR_W-V_WIDTH){1'b0}}, y0_in});
  assign y1W   = $signed({{(ERR_W-V_WIDTH){1'b0}}, y1_in});
  assign xDiff = x1W - x0W;
  assign yDiff = y1W - y0W;
  assign dxAbs = (xDiff < 0) ? -xDiff : xDiff;
  assign dyAbs = (yDiff < 0) ? -yDiff : yDiff;
  assign e2    = err_q + err_q;

  assign isLast    = (curX_q == endX_q) && (curY_q == endY_q);
  assign handshake = valid_q && pix_ready_in;

  always_comb begin
    state_d = state_q;
    curX_d  = curX_q;
    curY_d  = curY_q;
    endX_d  = endX_q;
    endY_d  = endY_q;
    color_d = color_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxNeg_d = sxNeg_q;
    syNeg_d = syNeg_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid_in) begin
          curX_d  = x0_in;
          curY_d  = y0_in;
          endX_d  = x1_in;
          endY_d  = y1_in;
          color_d = color_in;
          dx_d    = dxAbs;
          dy_d    = -dyAbs;
          sxNeg_d = (xDiff < 0);
          syNeg_d = (yDiff < 0);
          state_d = SETUP;
        end
      end
      SETUP: begin
        err_d   = dx_q + dy_q;
        valid_d = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        if (handshake) begin
          if (isLast) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Both axis decisions use the pre-step e2, so a diagonal step is one cycle.
            if (e2 >= dy_q) begin
              err_d  = err_d + dy_q;
              curX_d = sxNeg_q ? curX_q - H_WIDTH'(1) : curX_q + H_WIDTH'(1);
            end
            if (e2 <= dx_q) begin
              err_d  = err_d + dx_q;
              curY_d = syNeg_q ? curY_q - V_WIDTH'(1) : curY_q + V_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      curX_q  <= '0;
      curY_q  <= '0;
      endX_q  <= '0;
      endY_q  <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxNeg_q <= 1'b0;
      syNeg_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      curX_q  <= curX_d;
      curY_q  <= curY_d;
      endX_q  <= endX_d;
      endY_q  <= endY_d;
      color_q <= color_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxNeg_q <= sxNeg_d;
      syNeg_q <= syNeg_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign start_ready_out = (state_q == IDLE);
  assign pix_valid_out   = valid_q;
  assign pix_x_out       = curX_q;
  assign pix_y_out       = curY_q;
  assign pix_color_out   = color_q;
  assign pix_last_out    = valid_q && isLast;
  assign done_out        = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: hand-computed pixel lists plus a textbook
// Bresenham model for the full-screen diagonal.
module tb_line_rasterizer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_valid_in = 1'b0;
  logic        start_ready_out;
  logic [10:0] x0_in = '0, x1_in = '0;
  logic [9:0]  y0_in = '0, y1_in = '0;
  logic [23:0] color_in = '0;
  logic        pix_valid_out;
  logic        pix_ready_in = 1'b1;
  logic [10:0] pix_x_out;
  logic [9:0]  pix_y_out;
  logic [23:0] pix_color_out;
  logic        pix_last_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;
  int expX[$];
  int expY[$];
  int firstX, firstY, lastX, lastY;

  line_rasterizer #(.H_WIDTH(11), .V_WIDTH(10), .COLOR_W(24)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_valid_in(start_valid_in), .start_ready_out(start_ready_out),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .color_in(color_in),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
    .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .pix_color_out(pix_color_out), .pix_last_out(pix_last_out),
    .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Independent integer Bresenham used to build the expected pixel list.
  task automatic fillModel(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    expX.delete();
    expY.delete();
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      expX.push_back(x);
      expY.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input string tag, input int x0, input int y0, input int x1, input int y1, input logic [23:0] col);
    checkOutput({tag, " start_ready idle"}, 64'(start_ready_out), 64'd1);
    start_valid_in = 1'b1;
    x0_in = 11'(x0); y0_in = 10'(y0);
    x1_in = 11'(x1); y1_in = 10'(y1);
    color_in = col;
    @(negedge clk_in);
    start_valid_in = 1'b0;
    checkOutput({tag, " setup valid"}, 64'(pix_valid_out), 64'd0);
    checkOutput({tag, " setup start_ready"}, 64'(start_ready_out), 64'd0);
  endtask

  task automatic runLine(input string tag, input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] col, input bit bp, input bit poke);
    int idx = 0;
    int cyc = 0;
    bit fin = 0;
    bit stalled = 0;
    logic [10:0] holdX;
    logic [9:0]  holdY;
    logic        holdLast;
    logic        rdy;
    applyStimulus(tag, x0, y0, x1, y1, col);
    @(negedge clk_in);
    while (!fin && cyc < 6000) begin
      checkOutput({tag, " valid"}, 64'(pix_valid_out), 64'd1);
      if (stalled) begin
        checkOutput({tag, " stall x"}, 64'(pix_x_out), 64'(holdX));
        checkOutput({tag, " stall y"}, 64'(pix_y_out), 64'(holdY));
        checkOutput({tag, " stall last"}, 64'(pix_last_out), 64'(holdLast));
      end
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (poke && idx == 1) begin
        start_valid_in = 1'b1;
        x0_in = 11'd100; y0_in = 10'd100; x1_in = 11'd200; y1_in = 10'd50;
        color_in = 24'h123456;
        checkOutput({tag, " busy start_ready"}, 64'(start_ready_out), 64'd0);
      end
      pix_ready_in = rdy;
      if (pix_valid_out && rdy) begin
        if (idx < expX.size()) begin
          checkOutput({tag, " x"}, 64'(pix_x_out), 64'(expX[idx]));
          checkOutput({tag, " y"}, 64'(pix_y_out), 64'(expY[idx]));
          checkOutput({tag, " last"}, 64'(pix_last_out), 64'(idx == expX.size() - 1));
          checkOutput({tag, " color"}, 64'(pix_color_out), 64'(col));
        end
        if (idx == 0) begin firstX = pix_x_out; firstY = pix_y_out; end
        lastX = pix_x_out;
        lastY = pix_y_out;
        if (pix_last_out) begin
          fin = 1;
          start_valid_in = 1'b0;
        end
        idx++;
        stalled = 0;
      end else begin
        stalled  = pix_valid_out;
        holdX    = pix_x_out;
        holdY    = pix_y_out;
        holdLast = pix_last_out;
      end
      cyc++;
      @(negedge clk_in);
    end
    start_valid_in = 1'b0;
    pix_ready_in = 1'b1;
    checkOutput({tag, " finished in budget"}, 64'(fin), 64'd1);
    checkOutput({tag, " pixel count"}, 64'(idx), 64'(expX.size()));
    checkOutput({tag, " done pulse"}, 64'(done_out), 64'd1);
    checkOutput({tag, " valid after last"}, 64'(pix_valid_out), 64'd0);
    checkOutput({tag, " start_ready with done"}, 64'(start_ready_out), 64'd1);
    checkOutput({tag, " last after end"}, 64'(pix_last_out), 64'd0);
    @(negedge clk_in);
    checkOutput({tag, " done one cycle"}, 64'(done_out), 64'd0);
    checkOutput({tag, " nothing queued"}, 64'(pix_valid_out), 64'd0);
  endtask

  initial begin
    $display("[TB] line_rasterizer bench start");
    repeat (2) @(negedge clk_in);
    checkOutput("reset start_ready", 64'(start_ready_out), 64'd1);
    checkOutput("reset valid", 64'(pix_valid_out), 64'd0);
    checkOutput("reset last", 64'(pix_last_out), 64'd0);
    checkOutput("reset done", 64'(done_out), 64'd0);
    checkOutput("reset x", 64'(pix_x_out), 64'd0);
    checkOutput("reset y", 64'(pix_y_out), 64'd0);
    checkOutput("reset color", 64'(pix_color_out), 64'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    expX = '{0, 1, 2, 3};
    expY = '{0, 0, 0, 0};
    runLine("horiz", 0, 0, 3, 0, 24'hFF0000, 1'b0, 1'b0);

    expX = '{5, 5, 4, 4, 3, 3};
    expY = '{5, 4, 3, 2, 1, 0};
    runLine("steep", 5, 5, 3, 0, 24'h00FF00, 1'b0, 1'b0);

    expX = '{7};
    expY = '{9};
    runLine("degen", 7, 9, 7, 9, 24'h0000FF, 1'b0, 1'b0);

    expX = '{0, 0, 0, 0};
    expY = '{0, 1, 2, 3};
    runLine("bp", 0, 0, 0, 3, 24'hABCDEF, 1'b1, 1'b0);

    expX = '{10, 11, 12, 13, 14};
    expY = '{20, 21, 21, 22, 22};
    runLine("busy", 10, 20, 14, 22, 24'h55AA55, 1'b0, 1'b1);

    applyStimulus("rstmid", 0, 0, 10, 0, 24'h777777);
    pix_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checkOutput("rstmid drawing", 64'(pix_valid_out), 64'd1);
    checkOutput("rstmid x", 64'(pix_x_out), 64'd2);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    checkOutput("rstmid valid", 64'(pix_valid_out), 64'd0);
    checkOutput("rstmid start_ready", 64'(start_ready_out), 64'd1);
    checkOutput("rstmid done", 64'(done_out), 64'd0);
    @(negedge clk_in);
    checkOutput("rstmid no done", 64'(done_out), 64'd0);
    checkOutput("rstmid idle", 64'(pix_valid_out), 64'd0);

    fillModel(2047, 0, 0, 1023);
    checkOutput("extreme model count", 64'(expX.size()), 64'd2048);
    runLine("extreme", 2047, 0, 0, 1023, 24'h010203, 1'b0, 1'b0);
    checkOutput("extreme first x", 64'(firstX), 64'd2047);
    checkOutput("extreme first y", 64'(firstY), 64'd0);
    checkOutput("extreme last x", 64'(lastX), 64'd0);
    checkOutput("extreme last y", 64'(lastY), 64'd1023);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
